// File: rtl/d_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache. It turns single-word core
// requests into 128-bit line transfers: a write-back of the dirty victim, then a fill.
module d_cache_ctrl #(
    parameter int LINES   = 8,
    parameter int MEM_LAT = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         core_req_valid,
    output logic         core_req_ready,
    input  logic         core_req_we,
    input  logic [13:0]  core_req_addr,
    input  logic [31:0]  core_req_wdata,
    input  logic [3:0]   core_req_be,
    output logic         core_resp_valid,
    output logic [31:0]  core_resp_rdata,
    output logic         D_MEM_CSN,
    output logic         D_MEM_WEN,
    output logic [9:0]   D_MEM_ADDR,
    output logic [127:0] D_MEM_DOUT,
    input  logic [127:0] D_MEM_DI,
    output logic [31:0]  HIT_CNT,
    output logic [31:0]  MISS_CNT
);
    localparam int IW = $clog2(LINES);
    localparam int TW = 10 - IW;
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    // Handshake: a request is taken on a rising edge where core_req_valid and
    // core_req_ready are both 1; core_resp_valid is a single-cycle pulse per request.
    typedef enum logic [1:0] {IDLE, LOOKUP, WB, FILL} state_t;

    state_t         state;
    logic           r_we;
    logic [13:0]    r_addr;
    logic [31:0]    r_wdata;
    logic [3:0]     r_be;
    logic           replay;
    logic [CW-1:0]  cnt;
    logic [LINES-1:0] line_valid;
    logic [LINES-1:0] line_dirty;
    logic [TW-1:0]  tags [LINES];
    logic [127:0]   data [LINES];

    logic [IW-1:0]  idx;
    logic [TW-1:0]  tag;
    logic [1:0]     word;
    logic           hit;
    logic [127:0]   cur_line;
    logic [31:0]    cur_word;
    logic [127:0]   merged;

    assign idx      = r_addr[3+IW:4];
    assign tag      = r_addr[13:4+IW];
    assign word     = r_addr[3:2];
    assign cur_line = data[idx];
    assign cur_word = cur_line[32*word +: 32];
    assign hit      = line_valid[idx] && (tags[idx] == tag);

    always_comb begin
        merged = cur_line;
        for (int b = 0; b < 4; b++) begin
            if (r_be[b])
                merged[32*word + 8*b +: 8] = r_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state           <= IDLE;
            core_req_ready  <= 1'b0;
            core_resp_valid <= 1'b0;
            core_resp_rdata <= '0;
            D_MEM_CSN       <= 1'b1;
            D_MEM_WEN       <= 1'b1;
            D_MEM_ADDR      <= '0;
            D_MEM_DOUT      <= '0;
            HIT_CNT         <= '0;
            MISS_CNT        <= '0;
            r_we            <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_be            <= '0;
            replay          <= 1'b0;
            cnt             <= '0;
            line_valid      <= '0;
            line_dirty      <= '0;
            tags            <= '{default: '0};
            data            <= '{default: '0};
        end else begin
            case (state)
                IDLE: begin
                    core_resp_valid <= 1'b0;
                    if (core_req_ready && core_req_valid) begin
                        r_we           <= core_req_we;
                        r_addr         <= core_req_addr;
                        r_wdata        <= core_req_wdata;
                        r_be           <= core_req_be;
                        replay         <= 1'b0;
                        core_req_ready <= 1'b0;
                        state          <= LOOKUP;
                    end else begin
                        // Ready comes up one cycle after a response so the two never overlap.
                        core_req_ready <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (!replay && HIT_CNT != '1)
                            HIT_CNT <= HIT_CNT + 32'd1;
                        core_resp_valid <= 1'b1;
                        if (r_we) begin
                            data[idx]       <= merged;
                            line_dirty[idx] <= 1'b1;
                            core_resp_rdata <= '0;
                        end else begin
                            core_resp_rdata <= cur_word;
                        end
                        state <= IDLE;
                    end else begin
                        if (!replay && MISS_CNT != '1)
                            MISS_CNT <= MISS_CNT + 32'd1;
                        cnt       <= '0;
                        D_MEM_CSN <= 1'b0;
                        if (line_valid[idx] && line_dirty[idx]) begin
                            D_MEM_WEN  <= 1'b0;
                            D_MEM_ADDR <= {tags[idx], idx};
                            D_MEM_DOUT <= cur_line;
                            state      <= WB;
                        end else begin
                            D_MEM_WEN  <= 1'b1;
                            D_MEM_ADDR <= {tag, idx};
                            state      <= FILL;
                        end
                    end
                end
                WB: begin
                    if (cnt == CW'(MEM_LAT - 1)) begin
                        // Chip select stays low; the fill follows back-to-back.
                        cnt        <= '0;
                        D_MEM_WEN  <= 1'b1;
                        D_MEM_ADDR <= {tag, idx};
                        state      <= FILL;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FILL: begin
                    if (cnt == CW'(MEM_LAT - 1)) begin
                        data[idx]       <= D_MEM_DI;
                        tags[idx]       <= tag;
                        line_valid[idx] <= 1'b1;
                        line_dirty[idx] <= 1'b0;
                        replay          <= 1'b1;
                        D_MEM_CSN       <= 1'b1;
                        D_MEM_WEN       <= 1'b1;
                        state           <= LOOKUP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_d_cache_ctrl.sv
// Directed bench for d_cache_ctrl: stimulus pushes expected responses into a queue and a
// negedge monitor pops and compares them, together with latency and memory-port activity.
module tb_d_cache_ctrl;
    localparam int LAT = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         core_req_valid = 1'b0;
    logic         core_req_ready;
    logic         core_req_we = 1'b0;
    logic [13:0]  core_req_addr = '0;
    logic [31:0]  core_req_wdata = '0;
    logic [3:0]   core_req_be = '0;
    logic         core_resp_valid;
    logic [31:0]  core_resp_rdata;
    logic         D_MEM_CSN;
    logic         D_MEM_WEN;
    logic [9:0]   D_MEM_ADDR;
    logic [127:0] D_MEM_DOUT;
    logic [127:0] D_MEM_DI;
    logic [31:0]  HIT_CNT;
    logic [31:0]  MISS_CNT;

    d_cache_ctrl #(.LINES(8), .MEM_LAT(LAT)) dut (
        .CLK(CLK), .RST(RST),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_we(core_req_we), .core_req_addr(core_req_addr),
        .core_req_wdata(core_req_wdata), .core_req_be(core_req_be),
        .core_resp_valid(core_resp_valid), .core_resp_rdata(core_resp_rdata),
        .D_MEM_CSN(D_MEM_CSN), .D_MEM_WEN(D_MEM_WEN), .D_MEM_ADDR(D_MEM_ADDR),
        .D_MEM_DOUT(D_MEM_DOUT), .D_MEM_DI(D_MEM_DI),
        .HIT_CNT(HIT_CNT), .MISS_CNT(MISS_CNT)
    );

    always #5 CLK = ~CLK;

    // Line memory: word w of line l holds 0x1000_0000 | (l << 4) | w.
    logic [127:0] mem [1024];
    assign D_MEM_DI = mem[D_MEM_ADDR];

    initial begin
        for (int l = 0; l < 1024; l++)
            for (int w = 0; w < 4; w++)
                mem[l][32*w +: 32] = 32'h1000_0000 | 32'(l << 4) | 32'(w);
        forever begin
            @(negedge CLK);
            if (!D_MEM_CSN && !D_MEM_WEN) mem[D_MEM_ADDR] = D_MEM_DOUT;
        end
    end

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [31:0] exp_q[$];
    int lat_q[$];
    int acc_q[$];
    int resp_cnt = 0, acc_cnt = 0, csn_low = 0, wb_cyc = 0, fill_cyc = 0;
    logic [9:0]   wb_addr = '0, fill_addr = '0;
    logic [127:0] wb_dout = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s", name);
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RST) begin
            acc_q.delete();
        end else begin
            if (core_req_valid && core_req_ready) begin
                acc_q.push_back(cyc + 1);
                acc_cnt++;
            end
            if (!D_MEM_CSN) begin
                csn_low++;
                if (!D_MEM_WEN) begin
                    wb_cyc++;
                    wb_addr = D_MEM_ADDR;
                    wb_dout = D_MEM_DOUT;
                end else begin
                    fill_cyc++;
                    fill_addr = D_MEM_ADDR;
                end
            end
            if (core_resp_valid) begin
                resp_cnt++;
                chk("ready_during_resp", 128'(core_req_ready), 128'(0));
                if (exp_q.size() == 0 || lat_q.size() == 0 || acc_q.size() == 0) begin
                    fail_now("unexpected_resp");
                end else begin
                    int a, l;
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    l = lat_q.pop_front();
                    a = acc_q.pop_front();
                    chk("resp_rdata", 128'(core_resp_rdata), 128'(e));
                    chk("resp_latency", 128'(cyc - a), 128'(l));
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [13:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] exp_rd, input int lat);
        int k;
        @(posedge CLK);
        #1;
        core_req_valid = 1'b1;
        core_req_we    = we;
        core_req_addr  = addr;
        core_req_wdata = wd;
        core_req_be    = be;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!core_req_ready && k < 50);
        if (!core_req_ready) begin
            fail_now("accept_timeout");
            core_req_valid = 1'b0;
            return;
        end
        exp_q.push_back(exp_rd);
        lat_q.push_back(lat);
        @(posedge CLK);
        #1;
        core_req_valid = 1'b0;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        if (exp_q.size() != 0) begin
            fail_now("resp_timeout");
            exp_q.delete();
            lat_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int s0, s1, k;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ready", 128'(core_req_ready), 128'(0));
        chk("rst_resp_valid", 128'(core_resp_valid), 128'(0));
        chk("rst_rdata", 128'(core_resp_rdata), 128'(0));
        chk("rst_csn", 128'(D_MEM_CSN), 128'(1));
        chk("rst_wen", 128'(D_MEM_WEN), 128'(1));
        chk("rst_addr", 128'(D_MEM_ADDR), 128'(0));
        chk("rst_dout", D_MEM_DOUT, 128'(0));
        chk("rst_hit", 128'(HIT_CNT), 128'(0));
        chk("rst_miss", 128'(MISS_CNT), 128'(0));
        @(negedge CLK);
        RST = 1'b0;

        // Cold load miss fills line 0x004.
        s0 = fill_cyc;
        issue(1'b0, 14'h040, 32'h0, 4'h0, 32'h1000_0040, 2 + LAT);
        chk("t1_miss", 128'(MISS_CNT), 128'(1));
        chk("t1_hit", 128'(HIT_CNT), 128'(0));
        chk("t1_fill_cycles", 128'(fill_cyc - s0), 128'(LAT));
        chk("t1_fill_addr", 128'(fill_addr), 128'(10'h004));

        // Store merge on a hit, then load it back; no memory traffic.
        s0 = csn_low;
        issue(1'b1, 14'h044, 32'hDEAD_BEEF, 4'b0011, 32'h0, 1);
        issue(1'b0, 14'h044, 32'h0, 4'h0, 32'h1000_BEEF, 1);
        chk("t2_no_csn", 128'(csn_low - s0), 128'(0));
        chk("t2_hit", 128'(HIT_CNT), 128'(2));

        // Conflict miss on the dirty line: write-back then fill.
        s0 = wb_cyc;
        s1 = fill_cyc;
        issue(1'b0, 14'h0C0, 32'h0, 4'h0, 32'h1000_00C0, 2 + 2 * LAT);
        chk("t3_wb_cycles", 128'(wb_cyc - s0), 128'(LAT));
        chk("t3_wb_addr", 128'(wb_addr), 128'(10'h004));
        chk("t3_wb_dout", wb_dout, {32'h1000_0043, 32'h1000_0042, 32'h1000_BEEF, 32'h1000_0040});
        chk("t3_fill_cycles", 128'(fill_cyc - s1), 128'(LAT));
        chk("t3_fill_addr", 128'(fill_addr), 128'(10'h00C));
        chk("t3_mem_line4", mem[4], {32'h1000_0043, 32'h1000_0042, 32'h1000_BEEF, 32'h1000_0040});
        chk("t3_miss", 128'(MISS_CNT), 128'(2));

        // Top line of the address space.
        issue(1'b0, 14'h3FF0, 32'h0, 4'h0, 32'h1000_3FF0, 2 + LAT);
        chk("t4_fill_addr", 128'(fill_addr), 128'(10'h3FF));
        issue(1'b0, 14'h3FFC, 32'h0, 4'h0, 32'h1000_3FF3, 1);
        chk("t4_hit", 128'(HIT_CNT), 128'(3));
        chk("t4_miss", 128'(MISS_CNT), 128'(3));

        // Reset during the second FILL cycle.
        @(posedge CLK);
        #1;
        core_req_valid = 1'b1;
        core_req_we    = 1'b0;
        core_req_addr  = 14'h080;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!core_req_ready && k < 50);
        if (!core_req_ready) fail_now("t5_accept_timeout");
        @(posedge CLK);
        #1;
        core_req_valid = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        chk("t5_csn_in_fill", 128'(D_MEM_CSN), 128'(0));
        RST = 1'b1;
        #1;
        chk("t5_csn_async", 128'(D_MEM_CSN), 128'(1));
        chk("t5_hit_cleared", 128'(HIT_CNT), 128'(0));
        chk("t5_miss_cleared", 128'(MISS_CNT), 128'(0));
        repeat (2) @(posedge CLK);
        #1;
        chk("t5_ready_in_rst", 128'(core_req_ready), 128'(0));
        RST = 1'b0;
        @(posedge CLK);
        #1;
        chk("t5_ready_after", 128'(core_req_ready), 128'(1));
        issue(1'b0, 14'h080, 32'h0, 4'h0, 32'h1000_0080, 2 + LAT);
        chk("t5_miss", 128'(MISS_CNT), 128'(1));
        chk("t5_hit", 128'(HIT_CNT), 128'(0));

        // Valid held high through a miss: one accept, one response.
        s0 = acc_cnt;
        s1 = resp_cnt;
        @(posedge CLK);
        #1;
        exp_q.push_back(32'h1000_0100);
        lat_q.push_back(2 + LAT);
        core_req_valid = 1'b1;
        core_req_addr  = 14'h100;
        k = 0;
        do begin
            @(negedge CLK);
            #1;
            k++;
        end while (resp_cnt == s1 && k < 100);
        core_req_valid = 1'b0;
        if (resp_cnt == s1) begin
            fail_now("t6_resp_timeout");
            exp_q.delete();
            lat_q.delete();
        end
        repeat (5) @(negedge CLK);
        chk("t6_accepts", 128'(acc_cnt - s0), 128'(1));
        chk("t6_resps", 128'(resp_cnt - s1), 128'(1));
        chk("t6_miss", 128'(MISS_CNT), 128'(2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
